seq_chunk_adder: RTL
====================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 8, bits summed per clock cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present on X, Y, Cin, sub.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port X  input  WIDTH  operand A.
REQ-008 SHALL have port Y  input  WIDTH  operand B.
REQ-009 SHALL have port Cin  input  1  carry-in.
REQ-010 SHALL have port sub  input  1  mode: 0 add, 1 subtract.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port S  output  WIDTH  sum/difference.
REQ-014 SHALL have port Cout  output  1  carry out of MSB.
REQ-015 SHALL have port V  output  1  signed two's-complement overflow.
REQ-016 SHALL have port Z  output  1  S equals zero.

Function
REQ-017 SHALL compute {Cout,S} = X + (Y XOR {WIDTH{sub}}) + (Cin XOR sub); sub=1, Cin=0 gives X-Y; Cout=0 in subtract mode means borrow.
REQ-018 SHALL compute V = (A[MSB] == B'[MSB]) AND (S[MSB] != A[MSB]), with B' the post-XOR operand.
REQ-019 SHALL compute Z = 1 exactly when S == 0, regardless of Cout.
REQ-020 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-021 SHALL assert in_ready only in IDLE; accept occurs on the edge where in_valid AND in_ready; X, Y, Cin, sub captured into internal registers at that edge; IDLE->BUSY, chunk counter = 0.
REQ-022 SHALL, in BUSY, on each edge add chunk[counter] of captured operands plus the registered carry, write CHUNK result bits into S register, update the carry register, increment the counter.
REQ-023 SHALL transition BUSY->DONE on the edge processing chunk NCH-1; out_valid asserts exactly NCH cycles after the accept edge; Cout, V, Z valid in the same cycle.
REQ-024 SHALL hold out_valid, S, Cout, V, Z stable in DONE until the edge where out_valid AND out_ready; then DONE->IDLE.
REQ-025 SHALL ignore input changes while BUSY or DONE; only captured values affect the result.
REQ-026 SHALL, for CHUNK == WIDTH, produce the result after 1 BUSY cycle (NCH = 1).
REQ-027 SHALL deassert out_valid in IDLE and BUSY; S register retains the last completed result outside DONE.
REQ-028 SHALL give the next accept no earlier than the edge after the DONE->IDLE edge (throughput one op per NCH+2 cycles).

Reset
REQ-029 SHALL, when rst_n = 0, immediately and asynchronously force state IDLE, counter 0, carry 0, S = 0, Cout = 0, V = 0, Z = 0, out_valid = 0, in_ready = 0 while held low.
REQ-030 SHALL assert in_ready from the first cycle after rst_n rises.
REQ-031 SHALL discard any in-flight operation on reset mid-BUSY or mid-DONE; no result is emitted for it.

Verification
REQ-032 SHALL cover default params, add: X=00000001, Y=00000000, Cin=0 -> S=00000001, Cout=0, V=0, Z=0, out_valid 4 cycles after accept.
REQ-033 SHALL cover carry across every chunk: X=FFFFFFFF, Y=00000000, Cin=1 -> S=00000000, Cout=1, Z=1, V=0; and X=FF00FF00, Y=FFF00000, Cin=1 -> S=FEF0FF01, Cout=1, V=0.
REQ-034 SHALL cover overflow and subtract: X=7FFFFFFF, Y=00000001, add -> S=80000000, V=1, Cout=0; X=00000005, Y=00000007, sub=1, Cin=0 -> S=FFFFFFFE, Cout=0, V=0.
REQ-035 SHALL cover backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, input changes ignored; out_ready=1 -> IDLE next edge.
REQ-036 SHALL cover reset mid-BUSY after 2 chunks -> all outputs 0 asynchronously, no out_valid, next operation correct.
REQ-037 SHALL cover WIDTH=16, CHUNK=16 and WIDTH=64, CHUNK=4 with randomised operands checked against a full-width reference sum, including latency NCH.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Bit-serial-by-chunk adder/subtractor: captures operands, sums CHUNK bits per
// clock with a registered carry, and presents S/Cout/V/Z under valid/ready.
`timescale 1ns/1ps
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg, b_reg, acc_reg, acc_next, s_reg;
  logic             cout_reg, v_reg, z_reg;
  logic             in_ready_reg, out_valid_reg;

  logic [CHUNK-1:0] a_ch [NCH];
  logic [CHUNK-1:0] b_ch [NCH];
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk, accept, release_res;

  // Chunk views of the captured operands, and the working sum with the
  // current chunk patched in (the complete result on the last chunk).
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign a_ch[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_ch[gi] = b_reg[gi*CHUNK +: CHUNK];
      assign acc_next[gi*CHUNK +: CHUNK] = (cnt_reg == CW'(gi)) ? chunk_sum[CHUNK-1:0]
                                                              : acc_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_sum   = {1'b0, a_ch[cnt_reg]} + {1'b0, b_ch[cnt_reg]} + {{CHUNK{1'b0}}, carry_reg};
  assign last_chunk  = (cnt_reg == CW'(NCH - 1));
  assign accept      = in_valid && in_ready_reg;
  assign release_res = out_valid_reg && out_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (release_res) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      s_reg         <= '0;
      cout_reg      <= 1'b0;
      v_reg         <= 1'b0;
      z_reg         <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      // Registered so in_ready stays low during reset and rises one edge later.
      in_ready_reg <= (state_next == IDLE);
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= X;
            b_reg     <= Y ^ {WIDTH{sub}};
            carry_reg <= Cin ^ sub;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          acc_reg   <= acc_next;
          carry_reg <= chunk_sum[CHUNK];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_chunk) begin
            // Visible result only changes here, so S holds the last result otherwise.
            s_reg         <= acc_next;
            cout_reg      <= chunk_sum[CHUNK];
            v_reg         <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                             (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
            z_reg         <= (acc_next == '0);
            out_valid_reg <= 1'b1;
            cnt_reg       <= '0;
          end
        end
        DONE: begin
          if (release_res) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign S         = s_reg;
  assign Cout      = cout_reg;
  assign V         = v_reg;
  assign Z         = z_reg;

endmodule
